// File: rtl/rv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings and FSM states.
package rv_pkg;

    localparam logic [2:0] MD_OP_MUL    = 3'b000;
    localparam logic [2:0] MD_OP_MULH   = 3'b001;
    localparam logic [2:0] MD_OP_MULHSU = 3'b010;
    localparam logic [2:0] MD_OP_MULHU  = 3'b011;
    localparam logic [2:0] MD_OP_DIV    = 3'b100;
    localparam logic [2:0] MD_OP_DIVU   = 3'b101;
    localparam logic [2:0] MD_OP_REM    = 3'b110;
    localparam logic [2:0] MD_OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/rv_muldiv_negate.sv
// Combinational two's-complement conditional negate, used for operand magnitudes
// and for sign correction of the product, quotient and remainder.
module rv_muldiv_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? ((~value) + {{(W-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide sharing one 2*XLEN accumulator, with valid/ready on both sides.
module rv_muldiv_unit
    import rv_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    md_state_t         state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   operand;
    logic [2*XLEN-1:0] acc;
    logic              neg_res, neg_rem;
    logic [XLEN-1:0]   result_q;

    logic              accept, is_div, a_neg, b_neg, div_zero, ovf, fast, last_step;
    logic [XLEN-1:0]   a_mag, b_mag, fast_val, fix_val;

    assign accept    = in_valid && (state == MD_IDLE);
    assign is_div    = op[2];
    assign a_neg     = rs1[XLEN-1] && (op == MD_OP_MULH || op == MD_OP_MULHSU ||
                                       op == MD_OP_DIV  || op == MD_OP_REM);
    assign b_neg     = rs2[XLEN-1] && (op == MD_OP_MULH || op == MD_OP_DIV || op == MD_OP_REM);
    assign div_zero  = (rs2 == '0);
    assign ovf       = (op == MD_OP_DIV || op == MD_OP_REM) &&
                       (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == {XLEN{1'b1}});
    assign fast      = is_div && (div_zero || ovf);
    assign last_step = (cnt == CNT_W'(XLEN-1));

    rv_muldiv_negate #(.W(XLEN)) u_neg_a (.value(rs1), .negate(a_neg), .result(a_mag));
    rv_muldiv_negate #(.W(XLEN)) u_neg_b (.value(rs2), .negate(b_neg), .result(b_mag));

    // op[1] separates REM/REMU from DIV/DIVU within the divide group
    always_comb begin
        fast_val = '0;
        if (div_zero)
            fast_val = op[1] ? rs1 : {XLEN{1'b1}};
        else
            fast_val = op[1] ? '0 : rs1;
    end

    // Multiply: acc = {partial, multiplier}; add multiplicand on the LSB, then shift right
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
    assign mul_next = {mul_sum, acc[XLEN-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; shift left and trial-subtract
    logic [XLEN:0]     div_top;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff, div_rem;
    logic [2*XLEN-1:0] div_next;
    assign div_top  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_ge   = (div_top >= {1'b0, operand});
    assign div_diff = div_top[XLEN-1:0] - operand;
    assign div_rem  = div_ge ? div_diff : div_top[XLEN-1:0];
    assign div_next = {div_rem, acc[XLEN-2:0], div_ge};

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    rv_muldiv_negate #(.W(2*XLEN)) u_neg_prod (.value(acc), .negate(neg_res), .result(prod_fix));
    rv_muldiv_negate #(.W(XLEN)) u_neg_quo (.value(acc[XLEN-1:0]), .negate(neg_res), .result(quo_fix));
    rv_muldiv_negate #(.W(XLEN)) u_neg_rem (.value(acc[2*XLEN-1:XLEN]), .negate(neg_rem), .result(rem_fix));

    always_comb begin
        fix_val = '0;
        case (op_q)
            MD_OP_MUL:                  fix_val = prod_fix[XLEN-1:0];
            MD_OP_MULH, MD_OP_MULHSU,
            MD_OP_MULHU:                fix_val = prod_fix[2*XLEN-1:XLEN];
            MD_OP_DIV, MD_OP_DIVU:      fix_val = quo_fix;
            default:                    fix_val = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= MD_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: if (accept) state_next = fast ? MD_DONE : MD_CALC;
            MD_CALC: if (last_step) state_next = MD_FIX;
            MD_FIX:  state_next = MD_DONE;
            MD_DONE: if (out_ready) state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            op_q     <= '0;
            operand  <= '0;
            acc      <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                MD_IDLE: if (accept) begin
                    op_q    <= op;
                    neg_res <= a_neg ^ b_neg;
                    neg_rem <= a_neg;
                    cnt     <= '0;
                    if (fast) begin
                        result_q <= fast_val;
                    end else if (is_div) begin
                        acc     <= {{XLEN{1'b0}}, a_mag};
                        operand <= b_mag;
                    end else begin
                        acc     <= {{XLEN{1'b0}}, b_mag};
                        operand <= a_mag;
                    end
                end
                MD_CALC: begin
                    acc <= op_q[2] ? div_next : mul_next;
                    if (!last_step) cnt <= cnt + 1'b1;
                end
                MD_FIX:  result_q <= fix_val;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == MD_IDLE);
    assign out_valid = (state == MD_DONE);
    assign busy      = (state != MD_IDLE);
    assign result    = result_q;

endmodule
